// File: rtl/store_data_aligner_pkg.sv
// Shared encodings for the store-path data aligner and its lane shifter.
package store_data_aligner_pkg;

  // Byte lanes in one memory word.
  localparam int unsigned LANES = 4;

  // Store size encoding as driven by the execute stage.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Aligner FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } state_e;

  // Low-justified byte mask for a store of the given size; illegal sizes touch no lanes.
  function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
    logic [LANES-1:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane shifter: narrows store data to its size and places it on an
// 8-lane (two-word) window starting at the byte offset. Also usable for load merging.
module store_lane_shift
  import store_data_aligner_pkg::*;
(
  input  logic [1:0]         size,
  input  logic [1:0]         off,
  input  logic [LANES*8-1:0] data,
  output logic [LANES*16-1:0] d64,
  output logic [LANES*2-1:0]  be8
);

  logic [LANES-1:0]   mask;
  logic [LANES*8-1:0] masked;

  // Mask unused high bytes, then shift data and enables up by the byte offset.
  always_comb begin
    mask   = size_mask(size);
    masked = '0;
    for (int i = 0; i < LANES; i++) begin
      masked[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
    end
    d64 = {{(LANES*8){1'b0}}, masked} << {off, 3'b000};
    be8 = {{LANES{1'b0}}, mask} << off;
  end

endmodule

// File: rtl/store_data_aligner.sv
// Store-path data aligner: turns a register store request into one or two
// word-aligned, byte-enabled beats towards data memory.
module store_data_aligner
  import store_data_aligner_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_be,
  output logic              busy,
  output logic              err
);

  state_e state_q, state_d;

  logic              accept;
  logic              legal;
  logic [2*DATA_W-1:0] d64;
  logic [2*LANES-1:0]  be8;

  // Presented beat and the upper half held for a possible second beat.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;
  logic [DATA_W-1:0] hi_wdata_q;
  logic [LANES-1:0]  hi_be_q;
  logic              err_q;

  assign accept = req_valid && req_ready;
  assign legal  = (req_size != SZ_ILL);

  store_lane_shift u_lane_shift (
    .size (req_size),
    .off  (req_addr[1:0]),
    .data (req_data),
    .d64  (d64),
    .be8  (be8)
  );

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: illegal sizes are consumed in IDLE without issuing a beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && legal) state_d = ST_BEAT0;
      end
      ST_BEAT0: begin
        if (mem_ready) state_d = (hi_be_q != '0) ? ST_BEAT1 : ST_IDLE;
      end
      ST_BEAT1: begin
        if (mem_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state so reset drops them immediately.
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_BEAT0,
      ST_BEAT1: begin
        mem_valid = 1'b1;
        busy      = 1'b1;
      end
      default:  req_ready = 1'b0;
    endcase
  end

  // Beat datapath: load beat 0 on accept, swap in the upper half on the beat-0 handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      hi_wdata_q <= '0;
      hi_be_q    <= '0;
    end else if (state_q == ST_IDLE) begin
      if (accept && legal) begin
        addr_q     <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q    <= d64[DATA_W-1:0];
        be_q       <= be8[LANES-1:0];
        hi_wdata_q <= d64[2*DATA_W-1:DATA_W];
        hi_be_q    <= be8[2*LANES-1:LANES];
      end
    end else if (state_q == ST_BEAT0 && mem_ready && hi_be_q != '0) begin
      // Wraps modulo 2^ADDR_W at the top of the address space.
      addr_q  <= addr_q + ADDR_W'(4);
      wdata_q <= hi_wdata_q;
      be_q    <= hi_be_q;
    end
  end

  // Error pulse in the cycle after an illegal-size request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !legal;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_data_aligner.sv
// Self-checking bench for store_data_aligner: vector table plus scoreboard of
// expected memory beats, with hand-written backpressure and reset sequences.
module tb_store_data_aligner;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          beats;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  b0;
    logic [31:0] a1;
    logic [31:0] w1;
    logic [3:0]  b1;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  beat_t sb_q[$];
  beat_t mon_b;
  vec_t  vecs[10];

  store_data_aligner #(
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake (sampled mid-cycle, taken on the next rising edge) pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat_addr", {32'h0, mem_addr}, 64'hDEAD_DEAD);
      end else begin
        mon_b = sb_q.pop_front();
        chk("beat_addr", {32'h0, mem_addr}, {32'h0, mon_b.addr});
        chk("beat_wdata", {32'h0, mem_wdata}, {32'h0, mon_b.wdata});
        chk("beat_be", {60'h0, mem_be}, {60'h0, mon_b.be});
      end
    end
  end

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic send(input vec_t v);
    bit ok = 0;
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    if (v.beats >= 1) sb_q.push_back('{addr: v.a0, wdata: v.w0, be: v.b0});
    if (v.beats == 2) sb_q.push_back('{addr: v.a1, wdata: v.w1, be: v.b1});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hx;
    req_data  = 32'hx;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready && sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  vec_t bp_v;

  initial begin
    vecs[0] = '{32'h0000_1003, 32'h1234_56AB, 2'b00, 1, 32'h0000_1000, 32'hAB00_0000, 4'b1000, 0, 0, 0};
    vecs[1] = '{32'h0000_2002, 32'h0000_1234, 2'b01, 1, 32'h0000_2000, 32'h1234_0000, 4'b1100, 0, 0, 0};
    vecs[2] = '{32'h0000_3001, 32'hDEAD_BEEF, 2'b10, 2, 32'h0000_3000, 32'hADBE_EF00, 4'b1110,
                32'h0000_3004, 32'h0000_00DE, 4'b0001};
    vecs[3] = '{32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b10, 2, 32'hFFFF_FFFC, 32'hF00D_0000, 4'b1100,
                32'h0000_0000, 32'h0000_CAFE, 4'b0011};
    vecs[4] = '{32'h0000_4000, 32'h5555_5555, 2'b11, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{32'h0000_5000, 32'h0102_0304, 2'b10, 1, 32'h0000_5000, 32'h0102_0304, 4'b1111, 0, 0, 0};
    vecs[6] = '{32'h0000_6003, 32'hFFFF_A55A, 2'b01, 2, 32'h0000_6000, 32'h5A00_0000, 4'b1000,
                32'h0000_6004, 32'h0000_00A5, 4'b0001};
    vecs[7] = '{32'h0000_7000, 32'hFFFF_FF77, 2'b00, 1, 32'h0000_7000, 32'h0000_0077, 4'b0001, 0, 0, 0};
    vecs[8] = '{32'h0000_8001, 32'h1234_BEEF, 2'b01, 1, 32'h0000_8000, 32'h00BE_EF00, 4'b0110, 0, 0, 0};
    vecs[9] = '{32'h0000_9003, 32'h1122_3344, 2'b10, 2, 32'h0000_9000, 32'h4400_0000, 4'b1000,
                32'h0000_9004, 32'h0011_2233, 4'b0111};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    mem_ready = 1'b1;
    #12;
    chk("rst_req_ready", {63'h0, req_ready}, 64'd1);
    chk("rst_mem_valid", {63'h0, mem_valid}, 64'd0);
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_err", {63'h0, err}, 64'd0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'h0, mem_wdata}, 64'd0);
    chk("rst_mem_be", {60'h0, mem_be}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: with mem_ready high, ready returns after beats+1 cycles (illegal: immediately).
    foreach (vecs[i]) begin
      send(vecs[i]);
      @(negedge clk);
      chk("err_pulse", {63'h0, err}, {63'h0, vecs[i].beats == 0});
      chk("first_mem_valid", {63'h0, mem_valid}, {63'h0, vecs[i].beats != 0});
      chk("first_busy", {63'h0, busy}, {63'h0, vecs[i].beats != 0});
      chk("first_req_ready", {63'h0, req_ready}, {63'h0, vecs[i].beats == 0});
      for (int b = 1; b <= vecs[i].beats; b++) begin
        @(negedge clk);
        chk("ready_timing", {63'h0, req_ready}, {63'h0, b == vecs[i].beats});
      end
      if (vecs[i].beats == 0) begin
        @(negedge clk);
        chk("err_one_cycle", {63'h0, err}, 64'd0);
        chk("ill_no_valid", {63'h0, mem_valid}, 64'd0);
      end
      chk("sb_drained", {32'h0, 32'(sb_q.size())}, 64'd0);
      @(posedge clk);
      #1;
    end

    // Backpressure on beat 0 of a split store.
    bp_v = vecs[2];
    mem_ready = 1'b0;
    send(bp_v);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", {63'h0, mem_valid}, 64'd1);
      chk("bp_addr", {32'h0, mem_addr}, 64'h0000_3000);
      chk("bp_wdata", {32'h0, mem_wdata}, 64'hADBE_EF00);
      chk("bp_be", {60'h0, mem_be}, 64'b1110);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_beat1_valid", {63'h0, mem_valid}, 64'd1);
    chk("bp_beat1_addr", {32'h0, mem_addr}, 64'h0000_3004);
    chk("bp_beat1_be", {60'h0, mem_be}, 64'b0001);
    wait_idle();
    @(posedge clk);
    #1;

    // Reset while beat 1 is on the bus: valid drops at once, nothing replayed.
    send(vecs[3]);
    @(posedge clk);
    #1;
    chk("pre_rst_beat1_addr", {32'h0, mem_addr}, 64'h0);
    chk("pre_rst_beat1_valid", {63'h0, mem_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {63'h0, mem_valid}, 64'd0);
    chk("rst_async_ready", {63'h0, req_ready}, 64'd1);
    chk("rst_async_busy", {63'h0, busy}, 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_no_beat", {63'h0, mem_valid}, 64'd0);
      chk("post_rst_ready", {63'h0, req_ready}, 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
